// File: rtl/irrigation_timer_pkg.sv
// Shared types and constants for the irrigation countdown timer.
// Holds the FSM state enum, BCD digit widths, the packed MM:SS layout
// {min_d[1:0], min_u[3:0], sec_d[2:0], sec_u[3:0]} and the default presets.
package irrigation_timer_pkg;

  localparam int unsigned MIN_D_W = 2;
  localparam int unsigned MIN_U_W = 4;
  localparam int unsigned SEC_D_W = 3;
  localparam int unsigned SEC_U_W = 4;
  localparam int unsigned MMSS_W  = MIN_D_W + MIN_U_W + SEC_D_W + SEC_U_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [MIN_D_W-1:0] min_d;
    logic [MIN_U_W-1:0] min_u;
    logic [SEC_D_W-1:0] sec_d;
    logic [SEC_U_W-1:0] sec_u;
  } mmss_t;

  // 15:00 and 30:00 in the packed MM:SS layout
  localparam logic [MMSS_W-1:0] DEFAULT_SPRINKLER_PRESET = 13'h0A80;
  localparam logic [MMSS_W-1:0] DEFAULT_DRIPPER_PRESET   = 13'h1800;

  // Packed vector -> digit struct
  function automatic mmss_t mmss_unpack(input logic [MMSS_W-1:0] v);
    return mmss_t'(v);
  endfunction

  // Digit struct -> packed vector
  function automatic logic [MMSS_W-1:0] mmss_pack(input mmss_t d);
    return MMSS_W'(d);
  endfunction

endpackage

// File: rtl/bcd_mmss_down_counter.sv
// Four-digit MM:SS BCD down counter with synchronous load.
// Ports: clk, reset (async, active-high), load/load_value (preset load, wins
// over dec), dec (subtract one second, saturates at 00:00), digits (registered
// BCD digits), zero_c (digits == 00:00), last_c (digits == 00:01).
module bcd_mmss_down_counter
  import irrigation_timer_pkg::*;
#(
  parameter logic [MMSS_W-1:0] RESET_VALUE = DEFAULT_SPRINKLER_PRESET
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [MMSS_W-1:0] load_value,
  input  logic              dec,
  output mmss_t             digits,
  output logic              zero_c,
  output logic              last_c
);

  mmss_t dec_value;

  assign zero_c = (mmss_pack(digits) == MMSS_W'(0));
  assign last_c = (mmss_pack(digits) == MMSS_W'(1));

  // One-second decrement with the BCD borrow chain; holds at 00:00
  always_comb begin
    dec_value = digits;
    if (!zero_c) begin
      if (digits.sec_u != SEC_U_W'(0)) begin
        dec_value.sec_u = digits.sec_u - SEC_U_W'(1);
      end else begin
        dec_value.sec_u = SEC_U_W'(9);
        if (digits.sec_d != SEC_D_W'(0)) begin
          dec_value.sec_d = digits.sec_d - SEC_D_W'(1);
        end else begin
          dec_value.sec_d = SEC_D_W'(5);
          if (digits.min_u != MIN_U_W'(0)) begin
            dec_value.min_u = digits.min_u - MIN_U_W'(1);
          end else begin
            dec_value.min_u = MIN_U_W'(9);
            dec_value.min_d = digits.min_d - MIN_D_W'(1);
          end
        end
      end
    end
  end

  // Digit register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digits <= mmss_unpack(RESET_VALUE);
    end else if (load) begin
      digits <= mmss_unpack(load_value);
    end else if (dec) begin
      digits <= dec_value;
    end
  end

endmodule

// File: rtl/irrigation_countdown_timer.sv
// Irrigation cycle countdown timer: loads an MM:SS preset chosen by mode,
// counts down once per TICK_DIV clocks and flags completion.
// Ports: clk, reset (async, active-high), irrigation_on (run request level),
// abort (1-clk stop pulse), conflicting_values (sensor conflict level),
// sprinkler_mode_on (preset select), minutes_d/minutes_u/seconds_d/seconds_u
// (BCD display digits), running (in RUN), time_up (in DONE), done_pulse
// (1 clk on RUN->DONE), mode_latched (mode of the current cycle).
module irrigation_countdown_timer
  import irrigation_timer_pkg::*;
#(
  parameter int unsigned       TICK_DIV         = 50_000_000,
  parameter logic [MMSS_W-1:0] SPRINKLER_PRESET = DEFAULT_SPRINKLER_PRESET,
  parameter logic [MMSS_W-1:0] DRIPPER_PRESET   = DEFAULT_DRIPPER_PRESET
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               irrigation_on,
  input  logic               abort,
  input  logic               conflicting_values,
  input  logic               sprinkler_mode_on,
  output logic [MIN_D_W-1:0] minutes_d,
  output logic [MIN_U_W-1:0] minutes_u,
  output logic [SEC_D_W-1:0] seconds_d,
  output logic [SEC_U_W-1:0] seconds_u,
  output logic               running,
  output logic               time_up,
  output logic               done_pulse,
  output logic               mode_latched
);

  localparam int unsigned       PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICK_DIV - 1);

  state_t            state, state_next;
  logic [PRE_W-1:0]  pre_cnt, pre_cnt_next;
  logic              running_next, time_up_next, done_pulse_next, mode_next;
  logic              load_c, dec_c, tick_c, zero_c, last_c, stop_c;
  logic [MMSS_W-1:0] preset_c;
  mmss_t             digits;

  assign preset_c = sprinkler_mode_on ? SPRINKLER_PRESET : DRIPPER_PRESET;
  assign tick_c   = (pre_cnt == PRE_LAST);
  assign stop_c   = abort || !irrigation_on || conflicting_values;

  bcd_mmss_down_counter #(
    .RESET_VALUE (SPRINKLER_PRESET)
  ) u_counter (
    .clk        (clk),
    .reset      (reset),
    .load       (load_c),
    .load_value (preset_c),
    .dec        (dec_c),
    .digits     (digits),
    .zero_c     (zero_c),
    .last_c     (last_c)
  );

  // Next state, prescaler and counter control; stop beats expiry beats tick
  always_comb begin
    state_next      = state;
    pre_cnt_next    = pre_cnt;
    mode_next       = mode_latched;
    done_pulse_next = 1'b0;
    load_c          = 1'b0;
    dec_c           = 1'b0;
    case (state)
      IDLE: begin
        load_c       = 1'b1;
        mode_next    = sprinkler_mode_on;
        pre_cnt_next = '0;
        if (irrigation_on && !conflicting_values && !abort) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (stop_c) begin
          state_next   = IDLE;
          load_c       = 1'b1;
          pre_cnt_next = '0;
        end else if (zero_c) begin
          // preset of 00:00 expires on the first RUN clock
          state_next      = DONE;
          done_pulse_next = 1'b1;
        end else if (tick_c) begin
          pre_cnt_next = '0;
          dec_c        = 1'b1;
          if (last_c) begin
            state_next      = DONE;
            done_pulse_next = 1'b1;
          end
        end else begin
          pre_cnt_next = pre_cnt + PRE_W'(1);
        end
      end
      DONE: begin
        if (abort || !irrigation_on) begin
          state_next = IDLE;
          load_c     = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    running_next = (state_next == RUN);
    time_up_next = (state_next == DONE);
  end

  // State, prescaler and status registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      pre_cnt      <= '0;
      running      <= 1'b0;
      time_up      <= 1'b0;
      done_pulse   <= 1'b0;
      mode_latched <= 1'b1;
    end else begin
      state        <= state_next;
      pre_cnt      <= pre_cnt_next;
      running      <= running_next;
      time_up      <= time_up_next;
      done_pulse   <= done_pulse_next;
      mode_latched <= mode_next;
    end
  end

  assign minutes_d = digits.min_d;
  assign minutes_u = digits.min_u;
  assign seconds_d = digits.sec_d;
  assign seconds_u = digits.sec_u;

endmodule

// File: tb/tb_irrigation_countdown_timer.sv
// Bench for irrigation_countdown_timer with TICK_DIV = 4.
module tb_irrigation_countdown_timer;

  localparam int unsigned TICK_DIV = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       irrigation_on;
  logic       abort;
  logic       conflicting_values;
  logic       sprinkler_mode_on;
  logic [1:0] minutes_d;
  logic [3:0] minutes_u;
  logic [2:0] seconds_d;
  logic [3:0] seconds_u;
  logic       running;
  logic       time_up;
  logic       done_pulse;
  logic       mode_latched;

  int total = 0;
  int bad   = 0;
  logic [12:0] exp_q[$];

  irrigation_countdown_timer #(
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .irrigation_on      (irrigation_on),
    .abort              (abort),
    .conflicting_values (conflicting_values),
    .sprinkler_mode_on  (sprinkler_mode_on),
    .minutes_d          (minutes_d),
    .minutes_u          (minutes_u),
    .seconds_d          (seconds_d),
    .seconds_u          (seconds_u),
    .running            (running),
    .time_up            (time_up),
    .done_pulse         (done_pulse),
    .mode_latched       (mode_latched)
  );

  always #5 clk = ~clk;

  // Expected display for a remaining time given in seconds
  function automatic logic [12:0] exp_digits(input int s);
    int m;
    int sec;
    m   = s / 60;
    sec = s % 60;
    return {2'(m / 10), 4'(m % 10), 3'(sec / 10), 4'(sec % 10)};
  endfunction

  function automatic logic [12:0] got_digits();
    return {minutes_d, minutes_u, seconds_d, seconds_u};
  endfunction

  // Pushes expected digits for seconds from_s-1 down to to_s, then pops one
  // per TICK_DIV clocks; counts done pulses seen on the way.
  task automatic run_countdown(input int from_s, input int to_s, output int pulses);
    logic [12:0] e;
    pulses = 0;
    for (int s = from_s - 1; s >= to_s; s--) exp_q.push_back(exp_digits(s));
    while (exp_q.size() > 0) begin
      repeat (TICK_DIV) begin
        @(negedge clk);
        if (done_pulse) pulses++;
      end
      e = exp_q.pop_front();
      total++;
      if (got_digits() !== e) begin
        bad++;
        $display("FAIL countdown digits: got %h expected %h", got_digits(), e);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; irrigation_on = 1'b0; abort = 1'b0;
    conflicting_values = 1'b0; sprinkler_mode_on = 1'b1;
    #12;
    @(negedge clk);
    total++; if (got_digits() !== exp_digits(900)) begin bad++; $display("FAIL reset digits: got %h expected %h", got_digits(), exp_digits(900)); end
    total++; if (running !== 1'b0) begin bad++; $display("FAIL reset running: got %b expected 0", running); end
    total++; if (time_up !== 1'b0) begin bad++; $display("FAIL reset time_up: got %b expected 0", time_up); end
    total++; if (done_pulse !== 1'b0) begin bad++; $display("FAIL reset done_pulse: got %b expected 0", done_pulse); end
    total++; if (mode_latched !== 1'b1) begin bad++; $display("FAIL reset mode_latched: got %b expected 1", mode_latched); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sprinkler();
    int p;
    irrigation_on = 1'b1;
    @(negedge clk);
    total++; if (running !== 1'b1) begin bad++; $display("FAIL spr start running: got %b expected 1", running); end
    total++; if (got_digits() !== exp_digits(900)) begin bad++; $display("FAIL spr start digits: got %h expected %h", got_digits(), exp_digits(900)); end
    run_countdown(900, 0, p);
    total++; if (p !== 1) begin bad++; $display("FAIL spr done_pulse count: got %0d expected 1", p); end
    total++; if (done_pulse !== 1'b1) begin bad++; $display("FAIL spr done_pulse at zero: got %b expected 1", done_pulse); end
    total++; if (running !== 1'b0 || time_up !== 1'b1) begin bad++; $display("FAIL spr done state: got running=%b time_up=%b expected 0 1", running, time_up); end
    @(negedge clk);
    total++; if (done_pulse !== 1'b0 || time_up !== 1'b1) begin bad++; $display("FAIL spr hold: got pulse=%b time_up=%b expected 0 1", done_pulse, time_up); end
    total++; if (got_digits() !== 13'h0) begin bad++; $display("FAIL spr hold digits: got %h expected 0000", got_digits()); end
    irrigation_on = 1'b0;
    @(negedge clk);
    total++; if (time_up !== 1'b0) begin bad++; $display("FAIL spr release time_up: got %b expected 0", time_up); end
    total++; if (got_digits() !== exp_digits(900)) begin bad++; $display("FAIL spr release digits: got %h expected %h", got_digits(), exp_digits(900)); end
  endtask

  task automatic test_dripper();
    int p;
    sprinkler_mode_on = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (mode_latched !== 1'b0) begin bad++; $display("FAIL drip idle mode_latched: got %b expected 0", mode_latched); end
    total++; if (got_digits() !== exp_digits(1800)) begin bad++; $display("FAIL drip idle digits: got %h expected %h", got_digits(), exp_digits(1800)); end
    irrigation_on = 1'b1;
    @(negedge clk);
    total++; if (running !== 1'b1) begin bad++; $display("FAIL drip running: got %b expected 1", running); end
    run_countdown(1800, 0, p);
    total++; if (p !== 1 || time_up !== 1'b1) begin bad++; $display("FAIL drip end: got pulses=%0d time_up=%b expected 1 1", p, time_up); end
    abort = 1'b1;
    @(negedge clk);
    total++; if (time_up !== 1'b0 || running !== 1'b0) begin bad++; $display("FAIL drip abort in done: got time_up=%b running=%b expected 0 0", time_up, running); end
    abort = 1'b0; irrigation_on = 1'b0; sprinkler_mode_on = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_abort_mid();
    int p;
    irrigation_on = 1'b1;
    @(negedge clk);
    run_countdown(900, 451, p);
    abort = 1'b1;
    @(negedge clk);
    total++; if (running !== 1'b0 || done_pulse !== 1'b0 || p !== 0) begin bad++; $display("FAIL abort mid: got running=%b pulse=%b pulses=%0d expected 0 0 0", running, done_pulse, p); end
    total++; if (got_digits() !== exp_digits(900)) begin bad++; $display("FAIL abort mid reload: got %h expected %h", got_digits(), exp_digits(900)); end
    abort = 1'b0; irrigation_on = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_abort_at_zero();
    int p;
    irrigation_on = 1'b1;
    @(negedge clk);
    run_countdown(900, 1, p);
    repeat (TICK_DIV - 1) begin
      @(negedge clk);
      if (done_pulse) p++;
    end
    abort = 1'b1;
    @(negedge clk);
    if (done_pulse) p++;
    total++; if (p !== 0) begin bad++; $display("FAIL abort at zero pulses: got %0d expected 0", p); end
    total++; if (running !== 1'b0 || time_up !== 1'b0) begin bad++; $display("FAIL abort at zero state: got running=%b time_up=%b expected 0 0", running, time_up); end
    total++; if (got_digits() !== exp_digits(900)) begin bad++; $display("FAIL abort at zero reload: got %h expected %h", got_digits(), exp_digits(900)); end
    abort = 1'b0; irrigation_on = 1'b0;
    @(negedge clk);
    total++; if (done_pulse !== 1'b0) begin bad++; $display("FAIL abort at zero late pulse: got %b expected 0", done_pulse); end
  endtask

  task automatic test_conflict();
    conflicting_values = 1'b1; irrigation_on = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (running !== 1'b0) begin bad++; $display("FAIL conflict blocks start %0d: got %b expected 0", i, running); end
    end
    conflicting_values = 1'b0;
    @(negedge clk);
    total++; if (running !== 1'b1) begin bad++; $display("FAIL conflict cleared start: got %b expected 1", running); end
    conflicting_values = 1'b1;
    @(negedge clk);
    total++; if (running !== 1'b0 || got_digits() !== exp_digits(900)) begin bad++; $display("FAIL conflict stops run: got running=%b digits=%h expected 0 %h", running, got_digits(), exp_digits(900)); end
    conflicting_values = 1'b0; irrigation_on = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mode_toggle();
    int p;
    irrigation_on = 1'b1;
    @(negedge clk);
    run_countdown(900, 899, p);
    sprinkler_mode_on = 1'b0;
    run_countdown(899, 897, p);
    total++; if (mode_latched !== 1'b1 || running !== 1'b1) begin bad++; $display("FAIL toggle in run: got mode_latched=%b running=%b expected 1 1", mode_latched, running); end
    irrigation_on = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (mode_latched !== 1'b0) begin bad++; $display("FAIL toggle idle mode_latched: got %b expected 0", mode_latched); end
    total++; if (got_digits() !== exp_digits(1800)) begin bad++; $display("FAIL toggle idle digits: got %h expected %h", got_digits(), exp_digits(1800)); end
    sprinkler_mode_on = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int p;
    irrigation_on = 1'b1;
    @(negedge clk);
    run_countdown(900, 898, p);
    #2 reset = 1'b1;
    #1;
    total++; if (running !== 1'b0 || time_up !== 1'b0 || done_pulse !== 1'b0) begin bad++; $display("FAIL async reset flags: got %b%b%b expected 000", running, time_up, done_pulse); end
    total++; if (got_digits() !== exp_digits(900) || mode_latched !== 1'b1) begin bad++; $display("FAIL async reset digits: got %h ml=%b expected %h 1", got_digits(), mode_latched, exp_digits(900)); end
    @(negedge clk);
    reset = 1'b0; irrigation_on = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_sprinkler();
    test_dripper();
    test_abort_mid();
    test_abort_at_zero();
    test_conflict();
    test_mode_toggle();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
